// File: rtl/halt_tag_array_if.sv
// Controller-side bus of the way-halting tag array: lookup requests, fills,
// global invalidate and the registered lookup response.
interface halt_tag_array_if #(
    parameter int IDX_W = 3,
    parameter int WAY_W = 2,
    parameter int TAG_W = 24
);
    logic             lk_valid;
    logic             lk_ready;
    logic [IDX_W-1:0] lk_index;
    logic [TAG_W-1:0] lk_tag;

    logic             fill_valid;
    logic [IDX_W-1:0] fill_index;
    logic [WAY_W-1:0] fill_way;
    logic [TAG_W-1:0] fill_tag;

    logic             inv_all;

    logic             rsp_valid;
    logic             rsp_hit;
    logic [WAY_W-1:0] rsp_way;
    logic [WAY_W-1:0] rsp_victim;
    logic [WAY_W:0]   rsp_halt_cnt;

    modport master (
        output lk_valid, lk_index, lk_tag,
        output fill_valid, fill_index, fill_way, fill_tag,
        output inv_all,
        input  lk_ready,
        input  rsp_valid, rsp_hit, rsp_way, rsp_victim, rsp_halt_cnt
    );

    modport slave (
        input  lk_valid, lk_index, lk_tag,
        input  fill_valid, fill_index, fill_way, fill_tag,
        input  inv_all,
        output lk_ready,
        output rsp_valid, rsp_hit, rsp_way, rsp_victim, rsp_halt_cnt
    );
endinterface

// File: rtl/halt_tag_array.sv
// Set-associative tag store: halt-field pre-compare in stage 1, main-tag compare
// of surviving ways in stage 2, valid bits and true-LRU (age permutation) per set.
module halt_tag_array #(
    parameter int SETS   = 8,
    parameter int WAYS   = 4,
    parameter int TAG_W  = 24,
    parameter int HALT_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    halt_tag_array_if.slave bus
);
    localparam int IDX_W = $clog2(SETS);
    localparam int WAY_W = $clog2(WAYS);

    // Storage
    logic [TAG_W-1:0] tag_reg   [SETS][WAYS];
    logic [WAYS-1:0]  valid_reg [SETS];
    logic [WAY_W-1:0] age_reg   [SETS][WAYS];

    // Stage-2 pipeline registers
    logic             s2_valid_reg;
    logic [IDX_W-1:0] s2_index_reg;
    logic [TAG_W-1:0] s2_tag_reg;
    logic [WAYS-1:0]  s2_mask_reg;

    // Response registers
    logic             rsp_valid_reg;
    logic             rsp_hit_reg;
    logic [WAY_W-1:0] rsp_way_reg;
    logic [WAY_W-1:0] rsp_victim_reg;
    logic [WAY_W:0]   rsp_halt_cnt_reg;

    logic             accept;
    logic [WAYS-1:0]  lk_mask;
    logic [WAYS-1:0]  eff_mask;
    logic [WAYS-1:0]  eff_valid;
    logic [WAYS-1:0]  hit_vec;
    logic             hit_any;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] lru_way;
    logic [WAY_W-1:0] victim_way;
    logic [WAY_W:0]   halt_cnt;
    logic             hit_touch;
    logic [WAY_W-1:0] fill_ref_age;
    logic [WAY_W-1:0] hit_ref_age;

    assign bus.lk_ready = ~bus.fill_valid;
    assign accept       = bus.lk_valid & ~bus.fill_valid;

    // A fill landing on the set held in stage 2 is forwarded into that way's
    // compare so the response reflects the tag being written this edge.
    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_way
            logic                    fwd;
            logic [TAG_W-HALT_W-1:0] s2_main;

            assign lk_mask[gi] = valid_reg[bus.lk_index][gi]
                               & (tag_reg[bus.lk_index][gi][HALT_W-1:0] == bus.lk_tag[HALT_W-1:0]);

            assign fwd = bus.fill_valid
                       & (bus.fill_index == s2_index_reg)
                       & (bus.fill_way == WAY_W'(gi));

            assign s2_main = fwd ? bus.fill_tag[TAG_W-1:HALT_W]
                                 : tag_reg[s2_index_reg][gi][TAG_W-1:HALT_W];

            assign eff_valid[gi] = fwd | (valid_reg[s2_index_reg][gi] & ~bus.inv_all);

            assign eff_mask[gi] = fwd ? (bus.fill_tag[HALT_W-1:0] == s2_tag_reg[HALT_W-1:0])
                                      : s2_mask_reg[gi];

            assign hit_vec[gi] = eff_mask[gi] & eff_valid[gi]
                               & (s2_main == s2_tag_reg[TAG_W-1:HALT_W]);
        end
    endgenerate

    assign hit_any = |hit_vec;

    always_comb begin
        hit_way    = '0;
        lru_way    = '0;
        victim_way = '0;
        halt_cnt   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w]) begin
                hit_way = WAY_W'(w);
            end
        end
        for (int w = 0; w < WAYS; w++) begin
            halt_cnt = halt_cnt + (WAY_W + 1)'(eff_mask[w]);
            if (age_reg[s2_index_reg][w] == WAY_W'(WAYS - 1)) begin
                lru_way = WAY_W'(w);
            end
        end
        // Victim comes from the pre-edge state: lowest invalid way, else the LRU way.
        victim_way = lru_way;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_reg[s2_index_reg][w]) begin
                victim_way = WAY_W'(w);
            end
        end
    end

    // A fill into the same set pre-empts the LRU update of a concurrent hit.
    assign hit_touch = s2_valid_reg & hit_any
                     & ~(bus.fill_valid & (bus.fill_index == s2_index_reg));

    assign fill_ref_age = age_reg[bus.fill_index][bus.fill_way];
    assign hit_ref_age  = age_reg[s2_index_reg][hit_way];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < SETS; s++) begin
                valid_reg[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    tag_reg[s][w] <= '0;
                    age_reg[s][w] <= WAY_W'(WAYS - 1 - w);
                end
            end
        end else begin
            if (bus.inv_all) begin
                for (int s = 0; s < SETS; s++) begin
                    valid_reg[s] <= '0;
                end
            end
            if (bus.fill_valid) begin
                tag_reg[bus.fill_index][bus.fill_way]   <= bus.fill_tag;
                valid_reg[bus.fill_index][bus.fill_way] <= 1'b1;
                for (int w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == bus.fill_way) begin
                        age_reg[bus.fill_index][w] <= '0;
                    end else if (age_reg[bus.fill_index][w] < fill_ref_age) begin
                        age_reg[bus.fill_index][w] <= age_reg[bus.fill_index][w] + WAY_W'(1);
                    end
                end
            end
            if (hit_touch) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == hit_way) begin
                        age_reg[s2_index_reg][w] <= '0;
                    end else if (age_reg[s2_index_reg][w] < hit_ref_age) begin
                        age_reg[s2_index_reg][w] <= age_reg[s2_index_reg][w] + WAY_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_valid_reg     <= 1'b0;
            s2_index_reg     <= '0;
            s2_tag_reg       <= '0;
            s2_mask_reg      <= '0;
            rsp_valid_reg    <= 1'b0;
            rsp_hit_reg      <= 1'b0;
            rsp_way_reg      <= '0;
            rsp_victim_reg   <= '0;
            rsp_halt_cnt_reg <= '0;
        end else begin
            s2_valid_reg <= accept;
            if (accept) begin
                s2_index_reg <= bus.lk_index;
                s2_tag_reg   <= bus.lk_tag;
                s2_mask_reg  <= lk_mask;
            end
            rsp_valid_reg <= s2_valid_reg;
            if (s2_valid_reg) begin
                rsp_hit_reg      <= hit_any;
                rsp_way_reg      <= hit_way;
                rsp_victim_reg   <= victim_way;
                rsp_halt_cnt_reg <= halt_cnt;
            end
        end
    end

    assign bus.rsp_valid    = rsp_valid_reg;
    assign bus.rsp_hit      = rsp_hit_reg;
    assign bus.rsp_way      = rsp_way_reg;
    assign bus.rsp_victim   = rsp_victim_reg;
    assign bus.rsp_halt_cnt = rsp_halt_cnt_reg;
endmodule

// File: tb/tb_halt_tag_array.sv
// Bench for halt_tag_array: directed scenarios with fixed expectations, then
// randomized traffic checked against a recency-list reference model.
module tb_halt_tag_array;
    localparam int SETS   = 8;
    localparam int WAYS   = 4;
    localparam int TAG_W  = 24;
    localparam int HALT_W = 4;
    localparam int IDX_W  = 3;
    localparam int WAY_W  = 2;

    logic clk;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    halt_tag_array_if #(.IDX_W(IDX_W), .WAY_W(WAY_W), .TAG_W(TAG_W)) bus ();

    halt_tag_array #(.SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W), .HALT_W(HALT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: contents plus a per-set recency list (index 0 = MRU).
    logic [TAG_W-1:0] m_tag   [SETS][WAYS];
    bit               m_valid [SETS][WAYS];
    int               m_list  [SETS][WAYS];

    bit               p_valid;
    logic [IDX_W-1:0] p_idx;
    logic [TAG_W-1:0] p_tag;
    bit               p_mask [WAYS];

    bit               e_valid;
    bit               e_hit;
    int               e_way;
    int               e_victim;
    int               e_cnt;

    function automatic logic [8:0] pk(int v, int h, int w, int vi, int c);
        return {1'(v), 1'(h), 2'(w), 2'(vi), 3'(c)};
    endfunction

    function automatic logic [8:0] rsp_now();
        return {bus.rsp_valid, bus.rsp_hit, bus.rsp_way, bus.rsp_victim, bus.rsp_halt_cnt};
    endfunction

    task automatic idle();
        bus.lk_valid   = 1'b0;
        bus.lk_index   = '0;
        bus.lk_tag     = '0;
        bus.fill_valid = 1'b0;
        bus.fill_index = '0;
        bus.fill_way   = '0;
        bus.fill_tag   = '0;
        bus.inv_all    = 1'b0;
    endtask

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            for (int k = 0; k < WAYS; k++) begin
                m_tag[s][k]   = '0;
                m_valid[s][k] = 1'b0;
                m_list[s][k]  = WAYS - 1 - k;
            end
        end
        p_valid = 1'b0;
        e_valid = 1'b0;
    endtask

    task automatic touch(int s, int w);
        int p;
        p = 0;
        for (int k = 0; k < WAYS; k++) if (m_list[s][k] == w) p = k;
        for (int k = p; k > 0; k--) m_list[s][k] = m_list[s][k-1];
        m_list[s][0] = w;
    endtask

    // Advance one clock with the currently driven inputs, updating the model.
    task automatic tick();
        bit acc;
        bit n_mask [WAYS];
        bit mk;
        int fi;
        int s;
        acc = bus.lk_valid && !bus.fill_valid;
        fi  = int'(bus.fill_index);
        for (int w = 0; w < WAYS; w++) begin
            n_mask[w] = acc && m_valid[bus.lk_index][w]
                        && (m_tag[bus.lk_index][w][HALT_W-1:0] == bus.lk_tag[HALT_W-1:0]);
        end
        e_valid = p_valid;
        e_hit = 1'b0; e_way = 0; e_victim = 0; e_cnt = 0;
        s = int'(p_idx);
        if (p_valid) begin
            e_victim = m_list[s][WAYS-1];
            for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[s][w]) e_victim = w;
        end
        if (bus.inv_all) begin
            for (int ss = 0; ss < SETS; ss++) for (int w = 0; w < WAYS; w++) m_valid[ss][w] = 1'b0;
        end
        if (bus.fill_valid) begin
            m_tag[fi][bus.fill_way]   = bus.fill_tag;
            m_valid[fi][bus.fill_way] = 1'b1;
        end
        if (p_valid) begin
            for (int w = 0; w < WAYS; w++) begin
                if (bus.fill_valid && fi == s && int'(bus.fill_way) == w)
                    mk = (bus.fill_tag[HALT_W-1:0] == p_tag[HALT_W-1:0]);
                else
                    mk = p_mask[w];
                if (mk) e_cnt++;
                if (mk && m_valid[s][w] && !e_hit
                    && m_tag[s][w][TAG_W-1:HALT_W] == p_tag[TAG_W-1:HALT_W]) begin
                    e_hit = 1'b1;
                    e_way = w;
                end
            end
            $display("[TB] rsp set=%0d tag=%h exp hit=%0d way=%0d victim=%0d halt_cnt=%0d",
                     s, p_tag, e_hit, e_way, e_victim, e_cnt);
        end
        if (bus.fill_valid) touch(fi, int'(bus.fill_way));
        if (p_valid && e_hit && !(bus.fill_valid && fi == s)) touch(s, e_way);
        p_valid = acc;
        p_idx   = bus.lk_index;
        p_tag   = bus.lk_tag;
        p_mask  = n_mask;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_fill(int idx, int way, logic [TAG_W-1:0] tag);
        idle();
        bus.fill_valid = 1'b1;
        bus.fill_index = IDX_W'(idx);
        bus.fill_way   = WAY_W'(way);
        bus.fill_tag   = tag;
        tick();
        idle();
    endtask

    task automatic do_lookup(int idx, logic [TAG_W-1:0] tag);
        idle();
        bus.lk_valid = 1'b1;
        bus.lk_index = IDX_W'(idx);
        bus.lk_tag   = tag;
        tick();
        idle();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle();
        model_reset();
        repeat (2) @(negedge clk);
        tests++;
        if (rsp_now() !== pk(0, 0, 0, 0, 0)) begin
            fails++; $display("FAIL reset_outputs: got %b want %b", rsp_now(), pk(0, 0, 0, 0, 0));
        end
        tests++;
        if (bus.lk_ready !== 1'b1) begin
            fails++; $display("FAIL reset_lk_ready: got %b want 1", bus.lk_ready);
        end
        reset = 1'b1;
        do_lookup(3, 24'h123456);
        tests++;
        if (rsp_now() !== pk(1, 0, 0, 0, 0)) begin
            fails++; $display("FAIL reset_first_lookup: got %b want %b", rsp_now(), pk(1, 0, 0, 0, 0));
        end
        tick();
        tests++;
        if (bus.rsp_valid !== 1'b0) begin
            fails++; $display("FAIL rsp_pulse: got rsp_valid=%b want 0", bus.rsp_valid);
        end
    endtask

    task automatic test_halting();
        do_fill(3, 2, 24'hABCDE5);
        do_lookup(3, 24'hABCDE5);
        tests++;
        if (rsp_now() !== pk(1, 1, 2, 0, 1)) begin
            fails++; $display("FAIL halt_hit: got %b want %b", rsp_now(), pk(1, 1, 2, 0, 1));
        end
        do_lookup(3, 24'h000005);
        tests++;
        if (rsp_now() !== pk(1, 0, 0, 0, 1)) begin
            fails++; $display("FAIL halt_pass_main_miss: got %b want %b", rsp_now(), pk(1, 0, 0, 0, 1));
        end
        do_lookup(3, 24'hABCDE6);
        tests++;
        if (rsp_now() !== pk(1, 0, 0, 0, 0)) begin
            fails++; $display("FAIL halt_blocked: got %b want %b", rsp_now(), pk(1, 0, 0, 0, 0));
        end
    endtask

    task automatic test_lru();
        for (int w = 0; w < WAYS; w++) do_fill(1, w, TAG_W'(24'h10 + w));
        do_lookup(1, 24'h000010);
        tests++;
        if (rsp_now() !== pk(1, 1, 0, 0, 1)) begin
            fails++; $display("FAIL lru_hit_way0: got %b want %b", rsp_now(), pk(1, 1, 0, 0, 1));
        end
        do_lookup(1, 24'h0000FF);
        tests++;
        if (rsp_now() !== pk(1, 0, 0, 1, 0)) begin
            fails++; $display("FAIL lru_victim: got %b want %b", rsp_now(), pk(1, 0, 0, 1, 0));
        end
    endtask

    task automatic test_arbitration();
        idle();
        bus.fill_valid = 1'b1; bus.fill_index = 3'd5; bus.fill_way = 2'd1; bus.fill_tag = 24'h55AA01;
        bus.lk_valid   = 1'b1; bus.lk_index   = 3'd5; bus.lk_tag   = 24'h55AA01;
        #1;
        tests++;
        if (bus.lk_ready !== 1'b0) begin
            fails++; $display("FAIL arb_ready_low: got %b want 0", bus.lk_ready);
        end
        tick();
        bus.fill_valid = 1'b0;
        #1;
        tests++;
        if (bus.lk_ready !== 1'b1) begin
            fails++; $display("FAIL arb_ready_high: got %b want 1", bus.lk_ready);
        end
        tick();
        idle();
        tests++;
        if (bus.rsp_valid !== 1'b0) begin
            fails++; $display("FAIL arb_no_early_rsp: got rsp_valid=%b want 0", bus.rsp_valid);
        end
        tick();
        tests++;
        if (rsp_now() !== pk(1, 1, 1, 0, 1)) begin
            fails++; $display("FAIL arb_deferred_hit: got %b want %b", rsp_now(), pk(1, 1, 1, 0, 1));
        end
    endtask

    task automatic test_forwarding();
        idle();
        bus.lk_valid = 1'b1; bus.lk_index = 3'd2; bus.lk_tag = 24'h0000A7;
        tick();
        idle();
        bus.fill_valid = 1'b1; bus.fill_index = 3'd2; bus.fill_way = 2'd3; bus.fill_tag = 24'h0000A7;
        tick();
        idle();
        tests++;
        if (rsp_now() !== pk(1, 1, 3, 0, 1)) begin
            fails++; $display("FAIL forward_hit: got %b want %b", rsp_now(), pk(1, 1, 3, 0, 1));
        end
    endtask

    task automatic test_invalidate();
        do_fill(6, 2, 24'h777772);
        bus.lk_valid = 1'b1; bus.lk_index = 3'd6; bus.lk_tag = 24'h777772;
        tick();
        idle();
        bus.inv_all = 1'b1;
        tick();
        idle();
        tests++;
        if (rsp_now() !== pk(1, 0, 0, 0, 1)) begin
            fails++; $display("FAIL inv_inflight_miss: got %b want %b", rsp_now(), pk(1, 0, 0, 0, 1));
        end
    endtask

    task automatic test_reset_mid_lookup();
        do_fill(4, 1, 24'h444441);
        do_lookup(4, 24'h444441);
        tests++;
        if (rsp_now() !== pk(1, 1, 1, 0, 1)) begin
            fails++; $display("FAIL pre_reset_hit: got %b want %b", rsp_now(), pk(1, 1, 1, 0, 1));
        end
        bus.lk_valid = 1'b1; bus.lk_index = 3'd4; bus.lk_tag = 24'h444441;
        tick();
        idle();
        reset = 1'b0;
        #1;
        model_reset();
        tests++;
        if (rsp_now() !== pk(0, 0, 0, 0, 0) || bus.lk_ready !== 1'b1) begin
            fails++; $display("FAIL mid_reset_outputs: got %b ready=%b want %b ready=1",
                              rsp_now(), bus.lk_ready, pk(0, 0, 0, 0, 0));
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        tick();
        tests++;
        if (rsp_now() !== pk(0, 0, 0, 0, 0)) begin
            fails++; $display("FAIL dropped_lookup: got %b want %b", rsp_now(), pk(0, 0, 0, 0, 0));
        end
        do_lookup(4, 24'h444441);
        tests++;
        if (rsp_now() !== pk(1, 0, 0, 0, 0)) begin
            fails++; $display("FAIL post_reset_cleared: got %b want %b", rsp_now(), pk(1, 0, 0, 0, 0));
        end
    endtask

    function automatic logic [TAG_W-1:0] rnd_tag();
        logic [TAG_W-HALT_W-1:0] main_f;
        main_f = ($urandom_range(0, 1) == 1) ? 20'hA5A5A : 20'h00003;
        return {main_f, 4'($urandom_range(0, 3))};
    endfunction

    task automatic test_random_back_to_back();
        for (int i = 0; i < 400; i++) begin
            idle();
            if (i < 397) begin
                bus.lk_valid   = ($urandom_range(0, 9) < 7);
                bus.lk_index   = IDX_W'($urandom_range(0, 1));
                bus.lk_tag     = rnd_tag();
                bus.fill_valid = ($urandom_range(0, 9) < 3);
                bus.fill_index = IDX_W'($urandom_range(0, 1));
                bus.fill_way   = WAY_W'($urandom_range(0, WAYS - 1));
                bus.fill_tag   = rnd_tag();
                bus.inv_all    = ($urandom_range(0, 49) == 0);
            end
            #1;
            tests++;
            if (bus.lk_ready !== !bus.fill_valid) begin
                fails++; $display("FAIL rnd_lk_ready[%0d]: got %b want %b", i, bus.lk_ready, !bus.fill_valid);
            end
            tick();
            tests++;
            if (bus.rsp_valid !== e_valid) begin
                fails++; $display("FAIL rnd_rsp_valid[%0d]: got %b want %b", i, bus.rsp_valid, e_valid);
            end else if (e_valid && rsp_now() !== pk(1, int'(e_hit), e_way, e_victim, e_cnt)) begin
                fails++; $display("FAIL rnd_rsp[%0d]: got %b want %b (valid,hit,way,victim,cnt)",
                                  i, rsp_now(), pk(1, int'(e_hit), e_way, e_victim, e_cnt));
            end
        end
    endtask

    initial begin
        test_reset();
        test_halting();
        test_lru();
        test_arbitration();
        test_forwarding();
        test_invalidate();
        test_reset_mid_lookup();
        test_random_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/halt_tag_array.md
# halt_tag_array

Parametrised, set-associative tag store with way-halting lookup, valid bits and true-LRU replacement for the cache datapath. Each stored tag is split into a low halt field and a high main field. The halt fields of a set are compared first, and only the ways whose halt field matches go on to the main-tag compare, one cycle later. It sits between the cache controller (lookup/fill requests) and the data array (hit way / victim way).

## Interface
- `SETS`, 8: number of sets; power of 2, ≥2. `IDX_W = clog2(SETS)`.
- `WAYS`, 4: ways per set; power of 2, ≥2. `WAY_W = clog2(WAYS)`.
- `TAG_W`, 24: full tag width.
- `HALT_W`, 4: halt-field width; halt field = `tag[HALT_W-1:0]`, main field = `tag[TAG_W-1:HALT_W]`; requires `HALT_W < TAG_W`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `lk_valid`  in  1  lookup request.
- `lk_ready`  out  1  lookup accepted when `lk_valid & lk_ready`.
- `lk_index`  in  `IDX_W`  lookup set.
- `lk_tag`  in  `TAG_W`  lookup tag.
- `fill_valid`  in  1  write tag into (`fill_index`, `fill_way`); always accepted.
- `fill_index`  in  `IDX_W`  fill set.
- `fill_way`  in  `WAY_W`  fill way.
- `fill_tag`  in  `TAG_W`  tag written.
- `inv_all`  in  1  clear every valid bit.
- `rsp_valid`  out  1  lookup result valid, one-cycle pulse.
- `rsp_hit`  out  1  tag found in a valid way.
- `rsp_way`  out  `WAY_W`  hitting way; 0 on miss.
- `rsp_victim`  out  `WAY_W`  replacement way for the looked-up set.
- `rsp_halt_cnt`  out  `WAY_W+1`  number of ways that passed the halt compare and had their main tag compared.

## Operation
**Storage.** Per set and way: `TAG_W` tag bits, 1 valid bit, and a `WAY_W`-bit LRU age. Ages within a set are always a permutation of `0..WAYS-1`; age 0 is MRU.

**Stage 1** (cycle of acceptance):
- Read the halt fields of set `lk_index`.
- `mask[w] = valid[w] & (halt[w] == lk_tag[HALT_W-1:0])`.
- Register index, tag and mask.

**Stage 2** (next cycle):
- `hit[w] = mask[w] & valid[w] & (main[w] == lk_tag main field)`, using live tag and valid state.
- `rsp_hit = |hit`. `rsp_way` = lowest-index hitting way.
- `rsp_halt_cnt = popcount(mask)`.
- `rsp_victim` = lowest-index invalid way, else the way with age `WAYS-1`. It is computed from state before this edge's updates.

**Fill.**
- On the edge: write the tag, set valid, make the way MRU.
- Fill has priority over lookup: `lk_ready = ~fill_valid`. `lk_ready` is combinational; it is the only unregistered output.

**LRU update** (way `w` touched in set `s`):
- Every way with `age < age[w]` increments; `age[w] = 0`.
- A touch is a stage-2 hit or a fill.
- If a stage-2 hit and a fill target the same set on the same edge, only the fill update is applied.

**Forwarding.** If a fill writes set `s`, way `w` while the stage-2 register holds set `s`, then stage-2 `mask[w]` is overwritten with `(fill_tag halt field == registered lookup halt field)`. Stage 2 then sees the new tag.

**`inv_all`.**
- All valid bits clear on the edge. Tags and ages are retained.
- In-flight lookups resolve as misses, because stage 2 uses live valid bits.
- If asserted together with `fill_valid`, the fill's valid bit is set (fill wins).

**Duplicate tags** in a set (controller error): lowest-index way is reported; no error flag.

## Timing
- Lookup accepted in cycle t → `rsp_valid`/`rsp_*` registered, visible in cycle t+2. Throughput is 1 lookup/cycle when no fill is present.
- Fill takes effect on the edge ending its cycle. A lookup accepted the next cycle sees it.
- Reset (async assert, sync release):
  - all valid = 0, all tags = 0, age of way i = `WAYS-1-i` (initial victim way 0);
  - pipeline registers and `rsp_valid`, `rsp_hit`, `rsp_way`, `rsp_victim`, `rsp_halt_cnt` all = 0.
- Reset mid-lookup drops in-flight requests; no `rsp_valid` follows.
- Index and way arithmetic never wraps: all widths are exact powers of two.

## Test plan
All scenarios use default parameters.
- **Reset, then lookup** `idx=3`, `tag=0x123456` → at t+2: `rsp_valid=1`, `hit=0`, `victim=0`, `halt_cnt=0`. During reset all outputs are 0 and `lk_ready=1`.
- **Halting.** Fill set 3 way 2 with `0xABCDE5`.
  - Lookup `0xABCDE5` → `hit=1`, `way=2`, `halt_cnt=1`.
  - Lookup `0x000005` → `hit=0`, `halt_cnt=1`.
  - Lookup `0xABCDE6` → `hit=0`, `halt_cnt=0`.
- **LRU.** Fill set 1 ways 0,1,2,3 with `0x000010..0x000013` in order; lookup `0x000010` (hit way 0); then miss lookup `0x0000FF` → `victim=1`.
- **Arbitration.** `fill_valid` and `lk_valid` in the same cycle → `lk_ready=0`, fill written. The lookup is accepted next cycle and its response arrives 2 cycles later.
- **Forwarding.** Lookup set 2 `0x0000A7` accepted at t; fill set 2 way 3 `0x0000A7` at t+1 → at t+2: `hit=1`, `way=3`, `halt_cnt=1`.
- **Invalidate/reset.**
  - `inv_all` at t+1 for a lookup accepted at t that would hit → response is a miss with `victim=0`.
  - Assert reset at t+1 → no `rsp_valid`; all outputs are 0.
